lsu_mem_ctrl: RTL

Load/store unit for the pipelined core's MEM stage, sitting directly upstream of the byte-addressable data memory. It accepts one load or store request at a time from EX/MEM and drives the data memory's rd/wr/cs_n/addr/write_data pins with word-aligned accesses. Sub-word stores are handled by read-modify-write, and byte/half loads are lane-extracted and sign- or zero-extended. A single-cycle response returns load data or store completion to writeback, with an error flag for misaligned, illegal or out-of-range accesses.

---
 rtl/lsu_mem_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: issues word-aligned data-memory accesses, merges
// sub-word stores by read-modify-write and lane-extracts/extends sub-word loads.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_BYTES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic        dm_cs_n,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {IDLE, LD, RD, WR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;

    function automatic logic req_error(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a);
        logic        bad_f3;
        logic        misal;
        logic [32:0] last_byte;
        bad_f3    = we ? (f3 > 3'b010) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        misal     = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        last_byte = {1'b0, a[31:2], 2'b00} + 33'd3;
        return bad_f3 || misal || (last_byte >= 33'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Replace only the addressed byte/half of the word read back from memory.
    function automatic logic [31:0] merge_word(input logic [31:0] w, input logic [31:0] wd,
                                               input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] m;
        m = w;
        if (f3[1:0] == 2'b00) begin
            case (lane)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        return m;
    endfunction

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_error(req_we, req_funct3, req_addr)) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = LD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            LD: begin
                resp_valid_d = 1'b1;
                resp_data_d  = load_extract(dm_rdata, funct3_q, addr_q[1:0]);
                state_d      = IDLE;
            end
            RD: begin
                merge_d = merge_word(dm_rdata, wdata_q, funct3_q, addr_q[1:0]);
                state_d = WR;
            end
            default: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            merge_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Memory pins decode from registered state only, so reset drops them at once.
    assign req_ready  = (state_q == IDLE);
    assign dm_rd      = (state_q == LD) || (state_q == RD);
    assign dm_wr      = (state_q == WR);
    assign dm_cs_n    = !(dm_rd || dm_wr);
    assign dm_addr    = {addr_q[31:2], 2'b00};
    assign dm_wdata   = (state_q != WR) ? 32'd0 :
                        (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;

endmodule
